// File: rtl/rv_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// rv_hazard_ctrl
// Pipeline sequencing controller for a 5-stage core (IF, ID, EX, MEM, WB).
//
// Purpose:
//   - stall / flush / bubble controls for each pipeline register
//   - WB->ID register-file bypass selects and EX operand forwarding selects
//   - FSM that freezes the pipe while the data memory is busy, with a
//     sticky error when the memory never answers
//
// Ports:
//   i_hz_clk, i_hz_rstn          clock, async active-low reset
//   i_hz_id_rs1/2                ID source registers
//   i_hz_ex_rs1/2, i_hz_ex_rd    EX source / destination registers
//   i_hz_ex_rf_wen, _is_load     EX writes RF / is a load
//   i_hz_ex_mispredict           control transfer resolved wrong in EX
//   i_hz_mem_rd, _mem_rf_wen     MEM destination / writes RF
//   i_hz_wb_rd, _wb_rf_wen       WB destination / writes RF
//   i_hz_dmem_req, _dmem_ready   data memory handshake seen from MEM
//   o_hz_if_stall/_if_flush      PC + IF/ID hold / clear
//   o_hz_id_stall/_id_flush      ID/EX hold / bubble into EX
//   o_hz_ex_stall                EX/MEM hold
//   o_hz_mem_bubble              MEM/WB captures a NOP
//   o_hz_rf_rdata_sel1/2         ID takes WB write data for rs1/rs2
//   o_hz_fwd_a/b                 EX operand source: 00 RF, 01 MEM, 10 WB
//   o_hz_err                     sticky dmem timeout
//   o_hz_state                   0 RUN, 1 MEM_WAIT, 2 ERR
//   o_hz_perf_stall/_lu/_flush   perf counters (live only with HZ_PERF_CNT_EN)
//
// Optional build macro: HZ_PERF_CNT_EN
//   defined     -> saturating CNT_W-bit counters of ex_stall cycles,
//                  load-use bubbles and mispredict flushes
//   not defined -> perf outputs tied to 0, no counter flops
//
// FSM states:
//   state    | meaning
//   RUN      | normal flow; load-use / mispredict handling active
//   MEM_WAIT | dmem access outstanding; pipe frozen until ready
//   ERR      | dmem timed out; pipe frozen until reset
// ---------------------------------------------------------------------------
module rv_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_hz_clk,
  input  logic             i_hz_rstn,
  input  logic [4:0]       i_hz_id_rs1,
  input  logic [4:0]       i_hz_id_rs2,
  input  logic [4:0]       i_hz_ex_rs1,
  input  logic [4:0]       i_hz_ex_rs2,
  input  logic [4:0]       i_hz_ex_rd,
  input  logic             i_hz_ex_rf_wen,
  input  logic             i_hz_ex_is_load,
  input  logic             i_hz_ex_mispredict,
  input  logic [4:0]       i_hz_mem_rd,
  input  logic             i_hz_mem_rf_wen,
  input  logic [4:0]       i_hz_wb_rd,
  input  logic             i_hz_wb_rf_wen,
  input  logic             i_hz_dmem_req,
  input  logic             i_hz_dmem_ready,
  output logic             o_hz_if_stall,
  output logic             o_hz_if_flush,
  output logic             o_hz_id_stall,
  output logic             o_hz_id_flush,
  output logic             o_hz_ex_stall,
  output logic             o_hz_mem_bubble,
  output logic             o_hz_rf_rdata_sel1,
  output logic             o_hz_rf_rdata_sel2,
  output logic [1:0]       o_hz_fwd_a,
  output logic [1:0]       o_hz_fwd_b,
  output logic             o_hz_err,
  output logic [1:0]       o_hz_state,
  output logic [CNT_W-1:0] o_hz_perf_stall,
  output logic [CNT_W-1:0] o_hz_perf_lu,
  output logic [CNT_W-1:0] o_hz_perf_flush
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_TO = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic load_use;
  logic freeze;

  // Hazard detection (pure functions of the pipe contents)
  assign load_use = i_hz_ex_is_load && i_hz_ex_rf_wen && (i_hz_ex_rd != 5'd0) &&
                    ((i_hz_ex_rd == i_hz_id_rs1) || (i_hz_ex_rd == i_hz_id_rs2));

  // Freeze takes effect in the same cycle the access stalls, and drops in the
  // cycle ready arrives so the release cycle runs under the normal rules.
  always_comb begin
    freeze = 1'b0;
    case (state_q)
      ST_RUN:  freeze = i_hz_dmem_req && !i_hz_dmem_ready;
      ST_WAIT: freeze = !i_hz_dmem_ready;
      ST_ERR:  freeze = 1'b1;
      default: freeze = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_hz_clk or negedge i_hz_rstn) begin
    if (!i_hz_rstn) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (i_hz_dmem_req && !i_hz_dmem_ready) begin
          state_d = ST_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (i_hz_dmem_ready) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q >= WCNT_TO) begin
          state_d = ST_ERR;
        end else if (wcnt_q != '1) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Output logic; everything is held at 0 while reset is asserted
  always_comb begin
    o_hz_if_stall      = 1'b0;
    o_hz_if_flush      = 1'b0;
    o_hz_id_stall      = 1'b0;
    o_hz_id_flush      = 1'b0;
    o_hz_ex_stall      = 1'b0;
    o_hz_mem_bubble    = 1'b0;
    o_hz_rf_rdata_sel1 = 1'b0;
    o_hz_rf_rdata_sel2 = 1'b0;
    o_hz_fwd_a         = 2'b00;
    o_hz_fwd_b         = 2'b00;
    if (i_hz_rstn) begin
      if (freeze) begin
        o_hz_if_stall   = 1'b1;
        o_hz_id_stall   = 1'b1;
        o_hz_ex_stall   = 1'b1;
        o_hz_mem_bubble = 1'b1;
      end else begin
        // Mispredict discards the IF/ID instruction anyway, so holding it
        // for a load-use would be pointless.
        o_hz_if_flush = i_hz_ex_mispredict;
        o_hz_id_flush = i_hz_ex_mispredict || load_use;
        o_hz_if_stall = load_use && !i_hz_ex_mispredict;
      end

      if (i_hz_mem_rf_wen && (i_hz_mem_rd != 5'd0) && (i_hz_mem_rd == i_hz_ex_rs1))
        o_hz_fwd_a = 2'b01;
      else if (i_hz_wb_rf_wen && (i_hz_wb_rd != 5'd0) && (i_hz_wb_rd == i_hz_ex_rs1))
        o_hz_fwd_a = 2'b10;

      if (i_hz_mem_rf_wen && (i_hz_mem_rd != 5'd0) && (i_hz_mem_rd == i_hz_ex_rs2))
        o_hz_fwd_b = 2'b01;
      else if (i_hz_wb_rf_wen && (i_hz_wb_rd != 5'd0) && (i_hz_wb_rd == i_hz_ex_rs2))
        o_hz_fwd_b = 2'b10;

      o_hz_rf_rdata_sel1 = i_hz_wb_rf_wen && (i_hz_wb_rd != 5'd0) && (i_hz_wb_rd == i_hz_id_rs1);
      o_hz_rf_rdata_sel2 = i_hz_wb_rf_wen && (i_hz_wb_rd != 5'd0) && (i_hz_wb_rd == i_hz_id_rs2);
    end
  end

  assign o_hz_state = state_q;
  assign o_hz_err   = (state_q == ST_ERR);

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_lu_q, perf_flush_q;
  logic             lu_bubble, mp_flush;

  // A load-use bubble only counts when it is actually inserted for the load,
  // not when a mispredict flush in the same cycle already supplies it.
  assign lu_bubble = !freeze && load_use && !i_hz_ex_mispredict;
  assign mp_flush  = !freeze && i_hz_ex_mispredict;

  always_ff @(posedge i_hz_clk or negedge i_hz_rstn) begin
    if (!i_hz_rstn) begin
      perf_stall_q <= '0;
      perf_lu_q    <= '0;
      perf_flush_q <= '0;
    end else begin
      if (o_hz_ex_stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
      if (lu_bubble && (perf_lu_q != '1))        perf_lu_q    <= perf_lu_q + 1'b1;
      if (mp_flush && (perf_flush_q != '1))      perf_flush_q <= perf_flush_q + 1'b1;
    end
  end

  assign o_hz_perf_stall = perf_stall_q;
  assign o_hz_perf_lu    = perf_lu_q;
  assign o_hz_perf_flush = perf_flush_q;
`else
  assign o_hz_perf_stall = '0;
  assign o_hz_perf_lu    = '0;
  assign o_hz_perf_flush = '0;
`endif

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Directed bench for rv_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_rv_hazard_ctrl;

  logic       clk;
  logic       rstn;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_rf_wen, ex_is_load, ex_mispredict, mem_rf_wen, wb_rf_wen;
  logic       dmem_req, dmem_ready;
  logic       if_stall, if_flush, id_stall, id_flush, ex_stall, mem_bubble;
  logic       sel1, sel2, err;
  logic [1:0] fwd_a, fwd_b, state;
  logic [3:0] perf_stall, perf_lu, perf_flush;

  int n_cmp = 0;
  int n_bad = 0;

  // {if_stall, if_flush, id_stall, id_flush, ex_stall, mem_bubble}
  logic [5:0] ctrl;
  assign ctrl = {if_stall, if_flush, id_stall, id_flush, ex_stall, mem_bubble};

  localparam logic [5:0] C_IDLE   = 6'b000000;
  localparam logic [5:0] C_FREEZE = 6'b101011;
  localparam logic [5:0] C_LU     = 6'b100100;
  localparam logic [5:0] C_MP     = 6'b010100;

  rv_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .i_hz_clk           (clk),
    .i_hz_rstn          (rstn),
    .i_hz_id_rs1        (id_rs1),
    .i_hz_id_rs2        (id_rs2),
    .i_hz_ex_rs1        (ex_rs1),
    .i_hz_ex_rs2        (ex_rs2),
    .i_hz_ex_rd         (ex_rd),
    .i_hz_ex_rf_wen     (ex_rf_wen),
    .i_hz_ex_is_load    (ex_is_load),
    .i_hz_ex_mispredict (ex_mispredict),
    .i_hz_mem_rd        (mem_rd),
    .i_hz_mem_rf_wen    (mem_rf_wen),
    .i_hz_wb_rd         (wb_rd),
    .i_hz_wb_rf_wen     (wb_rf_wen),
    .i_hz_dmem_req      (dmem_req),
    .i_hz_dmem_ready    (dmem_ready),
    .o_hz_if_stall      (if_stall),
    .o_hz_if_flush      (if_flush),
    .o_hz_id_stall      (id_stall),
    .o_hz_id_flush      (id_flush),
    .o_hz_ex_stall      (ex_stall),
    .o_hz_mem_bubble    (mem_bubble),
    .o_hz_rf_rdata_sel1 (sel1),
    .o_hz_rf_rdata_sel2 (sel2),
    .o_hz_fwd_a         (fwd_a),
    .o_hz_fwd_b         (fwd_b),
    .o_hz_err           (err),
    .o_hz_state         (state),
    .o_hz_perf_stall    (perf_stall),
    .o_hz_perf_lu       (perf_lu),
    .o_hz_perf_flush    (perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0;
    ex_rf_wen = 1'b0; ex_is_load = 1'b0; ex_mispredict = 1'b0;
    mem_rf_wen = 1'b0; wb_rf_wen = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs are driven there and
  // outputs are sampled 4 time units later, mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    ex_mispredict = 1'b1;
    mem_rd = 5'd3; mem_rf_wen = 1'b1; ex_rs1 = 5'd3;
    wb_rd = 5'd4; wb_rf_wen = 1'b1; id_rs1 = 5'd4;
    tick(); #4;
    n_cmp++; if (ctrl !== C_IDLE) begin n_bad++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_IDLE); end
    n_cmp++; if (fwd_a !== 2'b00) begin n_bad++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a); end
    n_cmp++; if (sel1 !== 1'b0) begin n_bad++; $display("FAIL reset_sel1: got %b want 0", sel1); end
    n_cmp++; if (state !== 2'd0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_state: got state=%0d err=%b want 0/0", state, err); end
    tick();
    rstn = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_forwarding();
    idle_inputs();
    mem_rd = 5'd5; mem_rf_wen = 1'b1; wb_rd = 5'd5; wb_rf_wen = 1'b1;
    ex_rs1 = 5'd5; ex_rs2 = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd6;
    #4;
    n_cmp++; if (fwd_a !== 2'b01) begin n_bad++; $display("FAIL fwd_a_mem_prio: got %b want 01", fwd_a); end
    n_cmp++; if (fwd_b !== 2'b01) begin n_bad++; $display("FAIL fwd_b_mem_prio: got %b want 01", fwd_b); end
    n_cmp++; if ({sel1, sel2} !== 2'b10) begin n_bad++; $display("FAIL id_bypass: got %b want 10", {sel1, sel2}); end
    tick();
    mem_rf_wen = 1'b0;
    #4;
    n_cmp++; if (fwd_a !== 2'b10) begin n_bad++; $display("FAIL fwd_a_wb: got %b want 10", fwd_a); end
    tick();
    mem_rf_wen = 1'b1; ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; id_rs1 = 5'd0;
    #4;
    n_cmp++; if (fwd_a !== 2'b00) begin n_bad++; $display("FAIL fwd_a_x0: got %b want 00", fwd_a); end
    n_cmp++; if (sel1 !== 1'b0) begin n_bad++; $display("FAIL id_bypass_x0: got %b want 0", sel1); end
    tick();
    idle_inputs();
    ex_rs2 = 5'd9; wb_rd = 5'd9; wb_rf_wen = 1'b1; mem_rd = 5'd8; mem_rf_wen = 1'b1;
    #4;
    n_cmp++; if (fwd_b !== 2'b10) begin n_bad++; $display("FAIL fwd_b_wb: got %b want 10", fwd_b); end
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_is_load = 1'b1; ex_rf_wen = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd2; id_rs2 = 5'd7;
    #4;
    n_cmp++; if (ctrl !== C_LU) begin n_bad++; $display("FAIL load_use: got %b want %b", ctrl, C_LU); end
    tick();
    // load has moved to MEM; the dependent instruction is now in EX
    idle_inputs();
    mem_rd = 5'd7; mem_rf_wen = 1'b1; ex_rs2 = 5'd7; ex_rs1 = 5'd2;
    #4;
    n_cmp++; if (ctrl !== C_IDLE) begin n_bad++; $display("FAIL load_use_one_cycle: got %b want %b", ctrl, C_IDLE); end
    n_cmp++; if (fwd_b !== 2'b01) begin n_bad++; $display("FAIL load_use_fwd_b: got %b want 01", fwd_b); end
    tick();
    idle_inputs();
    ex_is_load = 1'b1; ex_rf_wen = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #4;
    n_cmp++; if (ctrl !== C_IDLE) begin n_bad++; $display("FAIL load_use_x0: got %b want %b", ctrl, C_IDLE); end
    tick();
    idle_inputs();
    ex_is_load = 1'b1; ex_rf_wen = 1'b0; ex_rd = 5'd7; id_rs1 = 5'd7;
    #4;
    n_cmp++; if (ctrl !== C_IDLE) begin n_bad++; $display("FAIL load_use_nowen: got %b want %b", ctrl, C_IDLE); end
    tick();
  endtask

  task automatic test_mispredict_lu();
    idle_inputs();
    ex_mispredict = 1'b1;
    ex_is_load = 1'b1; ex_rf_wen = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    #4;
    n_cmp++; if (ctrl !== C_MP) begin n_bad++; $display("FAIL mispredict_over_lu: got %b want %b", ctrl, C_MP); end
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_state [6];
    logic [5:0] exp_ctrl  [6];
    exp_state = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    exp_ctrl  = '{C_FREEZE, C_FREEZE, C_FREEZE, C_FREEZE, C_MP, C_IDLE};
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      dmem_req      = (c < 5);
      dmem_ready    = (c == 4);
      ex_mispredict = (c < 5);
      #4;
      n_cmp++; if (state !== exp_state[c]) begin n_bad++; $display("FAIL mem_wait_state[%0d]: got %0d want %0d", c, state, exp_state[c]); end
      n_cmp++; if (ctrl !== exp_ctrl[c]) begin n_bad++; $display("FAIL mem_wait_ctrl[%0d]: got %b want %b", c, ctrl, exp_ctrl[c]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic [1:0] exp_state [6];
    exp_state = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    idle_inputs();
    dmem_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #4;
      n_cmp++; if (state !== exp_state[c]) begin n_bad++; $display("FAIL timeout_state[%0d]: got %0d want %0d", c, state, exp_state[c]); end
      n_cmp++; if (err !== (c == 5)) begin n_bad++; $display("FAIL timeout_err[%0d]: got %b want %b", c, err, (c == 5)); end
      tick();
    end
    dmem_ready = 1'b1;
    #4;
    n_cmp++; if (ctrl !== C_FREEZE) begin n_bad++; $display("FAIL err_ignores_ready_ctrl: got %b want %b", ctrl, C_FREEZE); end
    tick();
    dmem_ready = 1'b0; dmem_req = 1'b0;
    #4;
    n_cmp++; if (state !== 2'd2 || err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got state=%0d err=%b want 2/1", state, err); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0 || err !== 1'b0 || ctrl !== C_IDLE) begin n_bad++; $display("FAIL err_reset: got state=%0d err=%b ctrl=%b want 0/0/%b", state, err, ctrl, C_IDLE); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    dmem_req = 1'b1;
    tick(); tick(); tick();
    #2;
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL mid_wait_pre: got %0d want 1", state); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mid_wait_reset: got %0d want 0", state); end
    tick();
    rstn = 1'b1;
    // counter must restart from scratch: full 4 wait cycles before ERR
    for (int c = 0; c < 6; c++) begin
      #4;
      n_cmp++; if (state !== ((c == 0) ? 2'd0 : (c == 5) ? 2'd2 : 2'd1)) begin
        n_bad++; $display("FAIL mid_wait_restart[%0d]: got %0d want %0d", c, state, ((c == 0) ? 2'd0 : (c == 5) ? 2'd2 : 2'd1));
      end
      tick();
    end
    idle_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_perf();
    logic [3:0] exp_lu, exp_fl, exp_st0, exp_st;
`ifdef HZ_PERF_CNT_EN
    exp_lu = 4'd3; exp_fl = 4'd2; exp_st0 = 4'd0; exp_st = 4'd15;
`else
    exp_lu = 4'd0; exp_fl = 4'd0; exp_st0 = 4'd0; exp_st = 4'd0;
`endif
    idle_inputs();
    ex_is_load = 1'b1; ex_rf_wen = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4;
    tick(); tick(); tick();
    idle_inputs();
    ex_mispredict = 1'b1;
    tick(); tick();
    idle_inputs();
    #4;
    n_cmp++; if (perf_lu !== exp_lu) begin n_bad++; $display("FAIL perf_lu: got %0d want %0d", perf_lu, exp_lu); end
    n_cmp++; if (perf_flush !== exp_fl) begin n_bad++; $display("FAIL perf_flush: got %0d want %0d", perf_flush, exp_fl); end
    n_cmp++; if (perf_stall !== exp_st0) begin n_bad++; $display("FAIL perf_stall_idle: got %0d want %0d", perf_stall, exp_st0); end
    tick();
    dmem_req = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    idle_inputs();
    #4;
    n_cmp++; if (perf_stall !== exp_st) begin n_bad++; $display("FAIL perf_stall_sat: got %0d want %0d", perf_stall, exp_st); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (perf_stall !== 4'd0) begin n_bad++; $display("FAIL perf_reset: got %0d want 0", perf_stall); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mispredict_lu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_hazard_ctrl.md
Name: rv_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Generates stall, flush and bubble controls for every pipeline register, including the stall/flush inputs of the ID stage.
- Generates the WB->ID register-file bypass selects and the EX operand forwarding selects.
- Owns a small FSM that freezes the pipe while the data memory is busy.
- Flags a sticky error when the data memory never responds.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before ERR.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- i_hz_clk  in  1  clock.
- i_hz_rstn  in  1  reset; asynchronous assert, active-low.
- i_hz_id_rs1, i_hz_id_rs2  in  5 each  source registers of the instruction in ID.
- i_hz_ex_rs1, i_hz_ex_rs2  in  5 each  source registers of the instruction in EX.
- i_hz_ex_rd  in  5  destination register of the instruction in EX.
- i_hz_ex_rf_wen  in  1  EX instruction writes the register file.
- i_hz_ex_is_load  in  1  EX instruction is a load.
- i_hz_ex_mispredict  in  1  branch/jalr resolved against its prediction in EX.
- i_hz_mem_rd  in  5  destination register in MEM.
- i_hz_mem_rf_wen  in  1  MEM instruction writes the register file.
- i_hz_wb_rd  in  5  destination register in WB.
- i_hz_wb_rf_wen  in  1  WB instruction writes the register file.
- i_hz_dmem_req  in  1  MEM stage issues a data memory access.
- i_hz_dmem_ready  in  1  data memory completes the access this cycle.
- o_hz_if_stall  out  1  hold PC and IF/ID.
- o_hz_if_flush  out  1  clear IF/ID to a NOP.
- o_hz_id_stall  out  1  hold ID/EX.
- o_hz_id_flush  out  1  clear ID/EX control (bubble into EX).
- o_hz_ex_stall  out  1  hold EX/MEM.
- o_hz_mem_bubble  out  1  MEM/WB captures a NOP.
- o_hz_rf_rdata_sel1, o_hz_rf_rdata_sel2  out  1 each  ID takes the WB write data for rs1/rs2.
- o_hz_fwd_a, o_hz_fwd_b  out  2 each  EX operand source: 00 register file, 01 MEM, 10 WB.
- o_hz_err  out  1  sticky dmem timeout.
- o_hz_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR.

Behaviour:
- Reset (i_hz_rstn low):
  - state=RUN, wait counter=0, o_hz_err=0.
  - All stall, flush, bubble, sel and fwd outputs forced to 0 while reset is asserted.
- All outputs except o_hz_err and o_hz_state are combinational from the inputs and state; zero added latency.
- Forwarding:
  - fwd_a=01 if mem_rf_wen && mem_rd!=0 && mem_rd==ex_rs1.
  - Otherwise fwd_a=10 if wb_rf_wen && wb_rd!=0 && wb_rd==ex_rs1.
  - Otherwise fwd_a=00.
  - MEM has priority over WB. fwd_b is identical, using ex_rs2.
- ID bypass: sel1=1 iff wb_rf_wen && wb_rd!=0 && wb_rd==id_rs1. sel2 is identical, using id_rs2.
- Load-use condition: ex_is_load && ex_rf_wen && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- FSM state RUN:
  - Load-use → if_stall=1 and id_flush=1: one bubble into EX, IF/ID held.
  - Mispredict → if_flush=1 and id_flush=1. Mispredict overrides load-use: if_stall=0 in that cycle.
  - dmem_req && !dmem_ready → next state MEM_WAIT, counter=1. The freeze applies in the same cycle: if_stall, id_stall and ex_stall all 1, mem_bubble=1, and all flushes suppressed.
- FSM state MEM_WAIT:
  - Freeze as above while dmem_ready=0; the counter increments each cycle.
  - dmem_ready=1 → freeze deasserts in that same cycle; next state RUN, counter=0. Mispredict or load-use held during the wait is applied in this release cycle under the RUN rules.
  - Counter reaching MEM_TIMEOUT with dmem_ready=0 → next state ERR.
- FSM state ERR:
  - o_hz_err=1, full freeze held permanently.
  - Exit only through reset.
  - Ignores dmem_ready.
- Reset asserted mid-wait returns to RUN immediately; the counter clears.
- The counter saturates; it does not wrap.

Optional Feature:
Macro: HZ_PERF_CNT_EN
- Defined: adds outputs o_hz_perf_stall, o_hz_perf_lu and o_hz_perf_flush, each CNT_W wide. They count, respectively:
  - cycles with ex_stall=1;
  - load-use bubbles;
  - mispredict flushes.
- Counters saturate at all-ones and reset to 0.
- Not defined: the ports exist but are tied to 0, and no counter flops are built.

Test Plan:
- Forwarding priority: mem_rd=5 (wen), wb_rd=5 (wen), ex_rs1=5 → fwd_a=01. Same case with mem_rf_wen=0 → fwd_a=10. With ex_rs1=0 → fwd_a=00.
- Load-use: ex_is_load=1, ex_rd=7, id_rs2=7 → if_stall=1, id_flush=1 for exactly one cycle. The following cycle (load now in MEM) → fwd_b=01 in EX.
- Mispredict plus load-use in the same cycle → if_flush=1, id_flush=1, if_stall=0.
- dmem_req=1 with ready low for 3 cycles → o_hz_state=1 for 3 cycles, all stalls 1, mem_bubble 1. Ready high → stalls 0 that cycle, state returns to 0 the next cycle.
- Timeout with MEM_TIMEOUT=4 and ready held low → o_hz_err=1, state=2 after 4 wait cycles. Ready pulses are ignored. Reset → state 0, err 0.
- Perf counters (HZ_PERF_CNT_EN defined, CNT_W=4) with 20 stall cycles → o_hz_perf_stall=15 (saturated). Without the macro → 0.
